// File: rtl/mvau_stream_ctrl.sv
// Input sequencer for the MVAU: buffers one activation vector while passing it
// through, then replays it once per remaining neuron fold with aligned weight addresses.
module mvau_stream_ctrl #(
    parameter int SIMD         = 2,
    parameter int TI           = 4,
    parameter int SF           = 4,
    parameter int NF           = 3,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_v,
    input  logic [SIMD*TI-1:0]      in_data,
    output logic                    in_rdy,
    input  logic                    out_stall,
    output logic                    out_v,
    output logic [SIMD*TI-1:0]      out_data,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    sf_clr
);

    localparam int DW    = SIMD * TI;
    localparam int SF_BW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NF_BW = (NF > 1) ? $clog2(NF) : 1;

    typedef enum logic {WRITE, READ} state_t;

    state_t            state;
    logic [SF_BW-1:0]  sf_cnt;
    logic [NF_BW-1:0]  nf_cnt;
    logic [DW-1:0]     buffer [SF];

    logic                    hold;
    logic                    accept;
    logic                    advance;
    logic                    sf_last;
    logic                    nf_last;
    logic [WMEM_ADDR_BW-1:0] addr_calc;
    logic [DW-1:0]           word;

    assign hold    = out_v && out_stall;
    assign in_rdy  = (state == WRITE) && !hold;
    assign accept  = in_v && in_rdy;
    assign advance = !hold && ((state == READ) || accept);
    assign sf_last = (sf_cnt == SF_BW'(SF - 1));
    assign nf_last = (nf_cnt == NF_BW'(NF - 1));

    // nf_cnt is zero throughout WRITE, so one formula covers both states
    assign addr_calc = WMEM_ADDR_BW'(nf_cnt) * WMEM_ADDR_BW'(SF) + WMEM_ADDR_BW'(sf_cnt);
    assign word      = (state == WRITE) ? in_data : buffer[sf_cnt];

    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[sf_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WRITE;
            sf_cnt    <= '0;
            nf_cnt    <= '0;
            out_v     <= 1'b0;
            out_data  <= '0;
            wmem_addr <= '0;
            sf_clr    <= 1'b0;
        end else if (advance) begin
            out_v     <= 1'b1;
            out_data  <= word;
            wmem_addr <= addr_calc;
            sf_clr    <= sf_last;
            if (sf_last) begin
                sf_cnt <= '0;
                if (state == WRITE) begin
                    if (NF > 1) begin
                        nf_cnt <= NF_BW'(1);
                        state  <= READ;
                    end
                end else if (nf_last) begin
                    nf_cnt <= '0;
                    state  <= WRITE;
                end else begin
                    nf_cnt <= nf_cnt + NF_BW'(1);
                end
            end else begin
                sf_cnt <= sf_cnt + SF_BW'(1);
            end
        end else if (!hold) begin
            out_v  <= 1'b0;
            sf_clr <= 1'b0;
        end
    end

endmodule
